// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: word-organised Avalon-MM RAM responder with wait states and a sticky fault flag.
module avalon_mem_slave #(
   parameter int          MEM_WORDS   = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
   parameter int          WAIT_CYCLES = 1,
   parameter              INIT_FILE   = "",
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        error
);
   localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
   localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 || WAIT_CYCLES < 1 || LFSR_SEED == 16'h0) begin : g_bad_cfg
      $error("avalon_mem_slave: illegal parameter set");
   end

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_load;
   logic [31:0]   a_addr;
   logic [31:0]   a_wdata;
   logic [3:0]    a_be;
   logic          a_rd;
   logic          a_wr;
   logic [31:0]   idx;
   logic          req;
   logic          fire;
   logic          bad;
   logic          changed;
   logic [31:0]   mem [MEM_WORDS];

   assign req         = read | write;
   assign fire        = state == WAIT && cnt == '0;
   assign idx         = (a_addr - BASE_ADDR) >> 2;
   assign bad         = (a_rd & a_wr) | (a_addr[1:0] != 2'b00) | (idx >= 32'(MEM_WORDS));
   assign changed     = address != a_addr || read != a_rd || write != a_wr ||
                        writedata != a_wdata || byteenable != a_be;
   assign waitrequest = state != ACK;

`ifdef AVALON_MEM_RANDOM_WAIT_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) lfsr <= LFSR_SEED;
      else if (state == IDLE && req) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign cnt_load = CW'(lfsr % WAIT_CYCLES);
`else
   assign cnt_load = CW'(WAIT_CYCLES - 1);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         readdata <= '0;
         error    <= 1'b0;
         a_addr   <= '0;
         a_wdata  <= '0;
         a_be     <= '0;
         a_rd     <= 1'b0;
         a_wr     <= 1'b0;
      end else begin
         state <= state == IDLE ? (req ? WAIT : IDLE) :
                  state == WAIT ? (cnt == '0 ? ACK : WAIT) : IDLE;
         if (state == IDLE && req) begin
            a_addr  <= address;
            a_wdata <= writedata;
            a_be    <= byteenable;
            a_rd    <= read;
            a_wr    <= write;
            cnt     <= cnt_load;
         end
         if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
         if (fire && (bad || a_rd)) readdata <= bad ? '0 : mem[idx[AW-1:0]];
         if ((fire && bad) || ((state == WAIT || state == ACK) && changed)) error <= 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (fire && a_wr && !bad)
         for (int i = 0; i < 4; i++)
            if (a_be[i]) mem[idx[AW-1:0]][8*i +: 8] <= a_wdata[8*i +: 8];
endmodule

// File: tb/tb_avalon_mem_slave.sv
// tb_avalon_mem_slave: scoreboard bench for avalon_mem_slave against a word-array reference model.
// Honours AVALON_MEM_RANDOM_WAIT_EN (wait range and reset-repeatability of the wait sequence).
module tb_avalon_mem_slave;
`ifdef AVALON_MEM_RANDOM_WAIT_EN
   localparam int WC = 4;
`else
   localparam int WC = 2;
`endif
   localparam int          MW   = 256;
   localparam logic [31:0] BASE = 32'hBFC0_0000;

   typedef struct { logic [31:0] rd; bit err; } exp_t;

   logic        clk = 0, reset = 0, read = 0, write = 0;
   logic [31:0] address = 0, writedata = 0;
   logic [3:0]  byteenable = 0;
   logic        waitrequest, error;
   logic [31:0] readdata;

   exp_t        sb[$];
   logic [31:0] mem_m [int];
   logic [31:0] rd_m = 0;
   bit          err_m = 0;
   int          tests = 0, fails = 0, cnt = 0;
   bit          was_ack = 0;
   int          waits[$];

   always #5 clk = ~clk;

   avalon_mem_slave #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
      .readdata(readdata), .error(error));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: word index rules, byte merge, sticky error, readdata hold
   task automatic model(input logic [31:0] a, input bit r, input bit w, input logic [31:0] wd,
                        input logic [3:0] be);
      logic [31:0] idx, v;
      idx = (a - BASE) >> 2;
      if ((r && w) || a[1:0] != 2'b00 || idx >= MW) begin
         err_m = 1;
         rd_m  = 0;
      end else if (w) begin
         v = mem_m.exists(int'(idx)) ? mem_m[int'(idx)] : 32'h0;
         for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
         mem_m[int'(idx)] = v;
      end else rd_m = mem_m[int'(idx)];
   endtask

   // called at posedge+1; returns at posedge+1 right after the ACK cycle
   task automatic xfer(input logic [31:0] a, input bit r, input bit w, input logic [31:0] wd,
                       input logic [3:0] be, input bit viol = 0);
      exp_t e;
      bit   done = 0;
      address = a; read = r; write = w; writedata = wd; byteenable = be;
      model(a, r, w, wd, be);
      if (viol) err_m = 1;
      e.rd = rd_m; e.err = err_m;
      sb.push_back(e);
      if (viol) begin
         @(posedge clk); #1;
         address = a ^ 32'h10;
      end
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         done = !waitrequest;
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL ack_timeout: got no ack expected ack within 50 cycles");
         sb.delete();
      end
      @(posedge clk); #1;
      read = 0; write = 0;
   endtask

   task automatic rst_pulse();
      @(negedge clk); #2;
      reset = 0;
      #1;
      chk("rst_waitrequest", waitrequest, 1);
      chk("rst_readdata", readdata, 0);
      chk("rst_error", error, 0);
      read = 0; write = 0; err_m = 0; rd_m = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (was_ack) chk("ack_one_cycle", waitrequest, 1);
      was_ack = 0;
      if (!reset) cnt = 0;
      else if (!waitrequest) begin
         was_ack = 1;
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_ack: got ack expected none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("readdata", readdata, e.rd);
            chk("error", error, e.err);
`ifdef AVALON_MEM_RANDOM_WAIT_EN
            tests++;
            if (cnt < 2 || cnt > WC + 1) begin
               fails++;
               $display("FAIL wait_range: got %0d expected 1..%0d", cnt - 1, WC);
            end
            waits.push_back(cnt - 1);
`else
            chk("wait_cycles", cnt, WC + 1);
`endif
         end
         cnt = 0;
      end else if (read || write) cnt++;
      else chk("idle_waitrequest", waitrequest, 1);
   end

   initial begin
      logic [31:0] old5;
      rst_pulse();
      xfer(BASE + 32'h10, 0, 1, 32'hDEADBEEF, 4'hF);
      xfer(BASE + 32'h10, 1, 0, 32'h0, 4'h0);
      chk("full_readback", readdata, 32'hDEADBEEF);
      xfer(BASE + 32'h20, 0, 1, 32'h11223344, 4'hF);
      xfer(BASE + 32'h20, 0, 1, 32'hAABBCCDD, 4'b0101);
      xfer(BASE + 32'h20, 1, 0, 32'h0, 4'h0);
      chk("partial_write", readdata, 32'h11BB33DD);
      for (int i = 0; i < 64; i++) xfer(BASE + 32'(4 * i), 0, 1, $urandom, 4'hF);
      repeat (300) begin
         logic [31:0] a;
         a = BASE + 32'(4 * $urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) xfer(a, 1, 0, $urandom, 4'h0);
         else xfer(a, 0, 1, $urandom, 4'($urandom_range(0, 15)));
      end
      xfer(BASE + 32'h2, 1, 0, 32'h0, 4'h0);
      chk("misaligned_read", readdata, 0);
      rst_pulse();
      xfer(BASE + 32'(4 * MW), 0, 1, 32'hCAFEF00D, 4'hF);
      xfer(BASE, 1, 0, 32'h0, 4'h0);
      rst_pulse();
      xfer(BASE + 32'h4, 1, 1, 32'h12345678, 4'hF);
      rst_pulse();
      xfer(BASE + 32'h10, 1, 0, 32'h0, 4'h0, 1);
      chk("protocol_error", error, 1);
      rst_pulse();
      old5 = mem_m[5];
      address = BASE + 32'h14; write = 1; writedata = ~old5; byteenable = 4'hF;
      @(posedge clk);
      rst_pulse();
      xfer(BASE + 32'h14, 1, 0, 32'h0, 4'h0);
      chk("abort_no_write", readdata, old5);
`ifdef AVALON_MEM_RANDOM_WAIT_EN
      begin
         int   ref_w[$];
         logic [3:0] seen;
         rst_pulse();
         waits.delete();
         repeat (1000) xfer(BASE + 32'(4 * $urandom_range(0, 63)), 1, 0, 32'h0, 4'h0);
         ref_w = waits;
         seen = 0;
         foreach (ref_w[i]) if (ref_w[i] >= 1 && ref_w[i] <= 4) seen[ref_w[i] - 1] = 1'b1;
         chk("all_waits_seen", seen, 4'hF);
         rst_pulse();
         waits.delete();
         repeat (1000) xfer(BASE + 32'(4 * $urandom_range(0, 63)), 1, 0, 32'h0, 4'h0);
         chk("wait_seq_len", waits.size(), ref_w.size());
         for (int i = 0; i < 1000 && i < waits.size() && i < ref_w.size(); i++)
            chk("wait_seq_repeat", waits[i], ref_w[i]);
      end
`endif
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
